antirebote_multicanal: RTL and testbench
========================================

# antirebote_multicanal

Parametrised multi-channel button conditioner: synchronises N_CH raw asynchronous button inputs, debounces each channel independently with a stability counter, and produces per-channel level, one-cycle press/release pulses, and an optional toggle (latching) output. It replaces the single-channel debounce/synchroniser pair in the switches/buttons peripheral. It feeds the memory-mapped input register of the mono-cycle CPU.

## Interface
- N_CH, 4, number of independent button channels (>=1)
- CNT_MAX, 100000, consecutive stable cycles required to accept a new level (>=1; 1 ms at 100 MHz)
- SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2)

- clck_i  in  1  system clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-low reset
- btn_i  in  N_CH  raw asynchronous button levels, 1 = pressed
- mode_i  in  N_CH  per-channel output mode: 0 = level, 1 = toggle
- btn_signal_o  out  N_CH  debounced level (mode 0) or toggle state (mode 1)
- press_o  out  N_CH  one-cycle pulse on accepted 0->1 transition
- release_o  out  N_CH  one-cycle pulse on accepted 1->0 transition

## Operation
- Per channel, fully independent:
  - sync: SYNC_STAGES-deep shift chain sampling btn_i[c]; last stage = s[c].
  - stable[c]: accepted debounced level register.
  - cnt[c]: width $clog2(CNT_MAX+1), unsigned.
  - tog[c]: toggle-state register.
- Counter rule, each edge:
  - s == stable: cnt <= 0.
  - s != stable and cnt < CNT_MAX-1: cnt <= cnt+1.
  - s != stable and cnt == CNT_MAX-1: stable <= s, cnt <= 0, pulse asserted (below).
- Net effect: stable changes only after s differs from it for CNT_MAX consecutive edges. Any disagreement gap restarts the count from 0. Counter never wraps.
- Pulses (registered):
  - press_o[c] = 1 for exactly the cycle in which stable[c] first reads 1.
  - release_o[c] = 1 for exactly the cycle in which stable[c] first reads 0.
  - Otherwise 0. Press and release are never both high on one channel.
- Toggle: tog[c] inverts on the same edge that stable[c] goes 0->1. Releases do not affect tog.
- Output select: btn_signal_o[c] = mode_i[c] ? tog[c] : stable[c].
  - Combinational mux of registered state; a mode_i change is reflected in the same cycle.
  - tog keeps updating regardless of mode_i.
- Reset (rst_i sampled low at an edge): sync chains, stable, cnt, tog, press_o, release_o all <= 0. Therefore every output reads 0 after the reset edge.
- Button held through reset release: treated as a new press. Full latency applies, then press_o fires and tog flips.

## Timing
- Latency: btn_i changes before edge E1 and stays stable. stable/press_o/release_o update after edge E(SYNC_STAGES+CNT_MAX).
- Minimum accepted pulse width: CNT_MAX cycles at s. Shorter pulses produce no output activity.
- Reset mid-count: count discarded; latency restarts from the first edge with rst_i high.
- Throughput: one accepted transition per channel per CNT_MAX cycles at most.
- Simultaneous transitions on several channels are accepted on the same edge if their timing coincides. No arbitration.

## Test plan
Bench parameters: N_CH=4, CNT_MAX=8, SYNC_STAGES=2.
- Clean press: btn_i[0] 0->1 before E1, held 20 cycles.
  - Required: btn_signal_o[0] and press_o[0] = 1 after E10.
  - press_o[0] low after E11; other channels stay 0.
- Bounce rejection: btn_i[1] toggles 5 high/3 low for 40 cycles, then held high.
  - Required: no press_o[1] during bounce.
  - Single press_o[1] exactly 10 edges after the final rising bounce.
- Release/boundary: channel 2 pressed, then btn_i[2] low for exactly 7 cycles, then low for 8 cycles.
  - Required: the 7-cycle low causes no change.
  - The 8-cycle low produces one release_o[2] pulse, and btn_signal_o[2] goes to 0.
- Toggle mode: mode_i[3]=1, two clean press/release pairs.
  - Required: btn_signal_o[3] 0->1 on first press, 1->0 on second press, unchanged on releases.
  - Switching mode_i[3] to 0 immediately shows stable[3].
- Reset mid-operation: btn_i[0] high, rst_i low at cnt=5, then released.
  - Required: all outputs 0 after reset edge.
  - press_o[0] fires 10 edges after the first edge with rst_i high.
- Parallel channels: btn_i[1:0] rise on the same cycle.
  - Required: press_o = 4'b0011 on one identical cycle, with exactly one pulse each.

Source files
------------

// File: rtl/antirebote_multicanal_if.sv
`default_nettype none
// ============================================================================
// antirebote_multicanal_if: button inputs, mode select and conditioned outputs
// Revision 1.0
// ============================================================================
interface antirebote_multicanal_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] btn_i;
  logic [N_CH-1:0] mode_i;
  logic [N_CH-1:0] btn_signal_o;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] release_o;

  modport master (
    output btn_i,
    output mode_i,
    input  btn_signal_o,
    input  press_o,
    input  release_o
  );

  modport slave (
    input  btn_i,
    input  mode_i,
    output btn_signal_o,
    output press_o,
    output release_o
  );
endinterface
`default_nettype wire

// File: rtl/antirebote_multicanal.sv
`default_nettype none
// ============================================================================
// antirebote_multicanal: per-channel synchroniser, stability-count debouncer,
// press/release pulses and toggle latch.  Revision 1.0
// ============================================================================
module antirebote_multicanal #(
  parameter int N_CH        = 4,
  parameter int CNT_MAX     = 100000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clck_i,
  input  logic                  rst_i,
  antirebote_multicanal_if.slave bus
);
  localparam int            CW     = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CNT_MAX - 1);

  genvar c;
  generate
    for (c = 0; c < N_CH; c++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CW-1:0]          r_cnt;
      logic                   r_stable;
      logic                   r_tog;
      logic                   r_press;
      logic                   r_release;
      logic                   w_s;

      assign w_s = r_sync[SYNC_STAGES-1];

      always_ff @(posedge clck_i) begin
        if (!rst_i) begin
          r_sync    <= '0;
          r_cnt     <= '0;
          r_stable  <= 1'b0;
          r_tog     <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.btn_i[c]};
          r_press   <= 1'b0;
          r_release <= 1'b0;
          // Any cycle of agreement restarts the stability window.
          if (w_s == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == C_LAST) begin
            r_stable  <= w_s;
            r_cnt     <= '0;
            r_press   <= w_s;
            r_release <= ~w_s;
            if (w_s) begin
              r_tog <= ~r_tog;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign bus.btn_signal_o[c] = bus.mode_i[c] ? r_tog : r_stable;
      assign bus.press_o[c]      = r_press;
      assign bus.release_o[c]    = r_release;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_antirebote_multicanal.sv
`default_nettype none
// ============================================================================
// tb_antirebote_multicanal: vector table, corner sequences and random stimulus
// against a sliding-window reference model.  Revision 1.0
// ============================================================================
module tb_antirebote_multicanal;
  localparam int N   = 4;
  localparam int CM  = 8;
  localparam int SS  = 2;
  localparam int WIN = SS + CM;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn = '0;
  logic [N-1:0] mode = '0;
  logic         mon_en = 1'b0;

  int checks   = 0;
  int failures = 0;
  int pcnt[N];
  int rcnt[N];

  // model state: raw sample history per channel, newest at index 0
  bit           hist[N][WIN];
  logic [N-1:0] m_stable = '0;
  logic [N-1:0] m_tog    = '0;
  logic [N-1:0] m_press  = '0;
  logic [N-1:0] m_rel    = '0;

  antirebote_multicanal_if #(.N_CH(N)) bus ();

  assign bus.btn_i  = btn;
  assign bus.mode_i = mode;

  antirebote_multicanal #(
    .N_CH(N), .CNT_MAX(CM), .SYNC_STAGES(SS)
  ) dut (
    .clck_i(clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // A new level is accepted once the last CM synchronised samples all disagree
  // with the accepted level; the synchronised sample is the raw one SS edges old.
  task automatic model_step();
    bit all_diff;
    for (int c = 0; c < N; c++) begin
      m_press[c] = 1'b0;
      m_rel[c]   = 1'b0;
      if (!rst) begin
        for (int k = 0; k < WIN; k++) hist[c][k] = 1'b0;
        m_stable[c] = 1'b0;
        m_tog[c]    = 1'b0;
      end else begin
        for (int k = WIN - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = btn[c];
        all_diff = 1'b1;
        for (int k = SS; k < WIN; k++)
          if (hist[c][k] == m_stable[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_stable[c] = ~m_stable[c];
          m_press[c]  = m_stable[c];
          m_rel[c]    = ~m_stable[c];
          if (m_stable[c]) m_tog[c] = ~m_tog[c];
        end
      end
    end
  endtask

  function automatic logic [N-1:0] exp_sig();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = mode[c] ? m_tog[c] : m_stable[c];
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (mon_en) begin
        chk("mdl_sig", 32'(bus.btn_signal_o), 32'(exp_sig()));
        chk("mdl_press", 32'(bus.press_o), 32'(m_press));
        chk("mdl_release", 32'(bus.release_o), 32'(m_rel));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    for (int c = 0; c < N; c++) begin
      pcnt[c] += int'(bus.press_o[c]);
      rcnt[c] += int'(bus.release_o[c]);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < N; c++) begin
      pcnt[c] = 0;
      rcnt[c] = 0;
    end
  endtask

  typedef struct {
    logic [N-1:0] btn;
    logic [N-1:0] mode;
    int           hold;
    logic [N-1:0] sig;
    logic [N-1:0] pm;
    logic [N-1:0] rm;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [N-1:0] pmask, rmask, pvec;
    int           first, p0, p1, hold[N];
    bit           relsig;

    tbl[0] = '{4'b0000, 4'b0000, 12, 4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{4'b1010, 4'b0000, 12, 4'b1010, 4'b1010, 4'b0000};
    tbl[2] = '{4'b0000, 4'b1000, 12, 4'b1000, 4'b0000, 4'b1010};
    tbl[3] = '{4'b0101, 4'b1111, 12, 4'b1111, 4'b0101, 4'b0000};
    tbl[4] = '{4'b0101, 4'b0000,  3, 4'b0101, 4'b0000, 4'b0000};
    tbl[5] = '{4'b0000, 4'b1111,  5, 4'b1111, 4'b0000, 4'b0000};
    tbl[6] = '{4'b0001, 4'b0001, 12, 4'b0001, 4'b0000, 4'b0100};
    tbl[7] = '{4'b0000, 4'b0000, 12, 4'b0000, 4'b0000, 4'b0001};

    clr();
    repeat (3) tick();
    mon_en = 1'b1;
    chk("reset_sig", 32'(bus.btn_signal_o), 0);
    chk("reset_press", 32'(bus.press_o), 0);
    rst = 1'b1;

    for (int v = 0; v < 8; v++) begin
      btn   = tbl[v].btn;
      mode  = tbl[v].mode;
      pmask = '0;
      rmask = '0;
      for (int i = 0; i < tbl[v].hold; i++) begin
        tick();
        pmask |= bus.press_o;
        rmask |= bus.release_o;
      end
      chk($sformatf("vec%0d_sig", v), 32'(bus.btn_signal_o), 32'(tbl[v].sig));
      chk($sformatf("vec%0d_press", v), 32'(pmask), 32'(tbl[v].pm));
      chk($sformatf("vec%0d_release", v), 32'(rmask), 32'(tbl[v].rm));
    end

    // reset clears toggle state too
    mode = 4'b1111;
    rst  = 1'b0;
    tick();
    chk("reset2_sig", 32'(bus.btn_signal_o), 0);
    rst  = 1'b1;
    mode = 4'b0000;

    // clean press latency
    btn = 4'b0001;
    repeat (9) tick();
    chk("clean_e9_press", 32'(bus.press_o), 0);
    tick();
    chk("clean_e10_sig", 32'(bus.btn_signal_o), 32'h1);
    chk("clean_e10_press", 32'(bus.press_o), 32'h1);
    tick();
    chk("clean_e11_press", 32'(bus.press_o), 0);
    repeat (9) tick();
    btn = 4'b0000;
    repeat (12) tick();

    // bounce rejection
    clr();
    for (int r = 0; r < 5; r++) begin
      btn[1] = 1'b1;
      repeat (5) tick();
      btn[1] = 1'b0;
      repeat (3) tick();
    end
    chk("bounce_nopress", 32'(pcnt[1]), 0);
    btn[1] = 1'b1;
    first  = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.press_o[1] && first == 0) first = i;
    end
    chk("bounce_latency", 32'(first), 10);
    chk("bounce_single", 32'(pcnt[1]), 1);
    btn[1] = 1'b0;
    repeat (12) tick();

    // release boundary: 7 low cycles rejected, 8 accepted
    btn[2] = 1'b1;
    repeat (12) tick();
    clr();
    btn[2] = 1'b0;
    repeat (7) tick();
    btn[2] = 1'b1;
    repeat (12) tick();
    chk("rel7_none", 32'(rcnt[2]), 0);
    chk("rel7_sig", 32'(bus.btn_signal_o[2]), 1);
    clr();
    relsig = 1'b1;
    btn[2] = 1'b0;
    repeat (8) tick();
    btn[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.release_o[2]) relsig = bus.btn_signal_o[2];
    end
    chk("rel8_count", 32'(rcnt[2]), 1);
    chk("rel8_sig", 32'(relsig), 0);
    btn[2] = 1'b0;
    repeat (24) tick();

    // toggle mode
    mode[3] = 1'b1;
    btn[3]  = 1'b1;
    repeat (12) tick();
    chk("tog_press1", 32'(bus.btn_signal_o[3]), 1);
    btn[3] = 1'b0;
    repeat (12) tick();
    chk("tog_rel1", 32'(bus.btn_signal_o[3]), 1);
    btn[3] = 1'b1;
    repeat (12) tick();
    chk("tog_press2", 32'(bus.btn_signal_o[3]), 0);
    mode[3] = 1'b0;
    #1;
    chk("tog_mode_level", 32'(bus.btn_signal_o[3]), 1);
    mode[3] = 1'b1;
    #1;
    chk("tog_mode_back", 32'(bus.btn_signal_o[3]), 0);
    btn[3] = 1'b0;
    repeat (12) tick();
    chk("tog_rel2", 32'(bus.btn_signal_o[3]), 0);

    // reset mid-count
    mode   = 4'b0000;
    btn[0] = 1'b1;
    repeat (7) tick();
    rst = 1'b0;
    tick();
    chk("rstmid_sig", 32'(bus.btn_signal_o), 0);
    chk("rstmid_press", 32'(bus.press_o), 0);
    chk("rstmid_release", 32'(bus.release_o), 0);
    rst   = 1'b1;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.press_o[0] && first == 0) first = i;
    end
    chk("rstmid_latency", 32'(first), 10);
    btn = 4'b0000;
    repeat (12) tick();

    // parallel channels
    clr();
    btn  = 4'b0011;
    pvec = '0;
    p0   = 0;
    p1   = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (bus.press_o[0] && p0 == 0) p0 = i;
      if (bus.press_o[1] && p1 == 0) p1 = i;
      if (bus.press_o != 0 && pvec == 0) pvec = bus.press_o;
    end
    chk("par_vec", 32'(pvec), 32'h3);
    chk("par_same", 32'(p0), 32'(p1));
    chk("par_cnt0", 32'(pcnt[0]), 1);
    chk("par_cnt1", 32'(pcnt[1]), 1);
    btn = 4'b0000;
    repeat (12) tick();

    // random traffic against the model
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          btn[c]  = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, 12));
        end
        hold[c]--;
      end
      if ($urandom_range(0, 15) == 0) mode = N'($urandom);
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
